uart_rx: RTL
============

# uart_rx

UART receive front end: it deserialises the `rx` line into bytes and hands them to the command/response FSM through a valid/ready handshake. The block oversamples with a baud-rate counter and samples each bit once, in the middle of the bit. It checks even parity and the stop bit, then attaches error flags to each byte. The block sits directly between the `rx` pin and the consumer of `read_data` in the UART command path.

## Interface
- `BR`, 434, clock cycles per bit (50 MHz / 115200).
- `DATA_WIDTH`, 8, data bits per frame; sent LSB first.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous reset, active-high.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  DATA_WIDTH  received byte; meaningful while `rx_vld`=1; reset 0.
- `rx_vld`  output  1  byte available; reset 0.
- `rx_rdy`  input  1  consumer accepts; a transfer occurs when `rx_vld && rx_rdy`.
- `parity_err`  output  1  parity mismatch for the held byte; qualified by `rx_vld`; reset 0.
- `frame_err`  output  1  stop bit sampled low for the held byte; qualified by `rx_vld`; reset 0.
- `overrun`  output  1  one-cycle pulse when a completed frame is dropped; reset 0.

Clock is one domain; reset is synchronous and active-high.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. A further delay flop gives `rx_d`. All three flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP. `br_cnt` is $clog2(BR) bits wide. `bit_cnt` is $clog2(DATA_WIDTH) bits wide.
- IDLE: a falling edge (`rx_d`=1, `rx_s`=0) clears `br_cnt` and moves to START. A level-low line with no falling edge (break) never starts a frame.
- START: when `br_cnt`==BR/2-1, check `rx_s`.
  - `rx_s`=0: go to DATA and clear `br_cnt`.
  - `rx_s`=1: glitch; go to IDLE with no output.
- DATA: when `br_cnt`==BR-1, shift `rx_s` into the MSB of the shift register (so the LSB-first byte lands correctly), increment `bit_cnt`, and clear `br_cnt`.
  - After bit DATA_WIDTH-1, go to PARITY (or to STOP if parity is compiled out).
- PARITY: when `br_cnt`==BR-1, compute `perr = rx_s ^ (^shift)`, using even parity. Go to STOP.
- STOP: when `br_cnt`==BR-1, compute `ferr = ~rx_s`, complete the frame, and go to IDLE.
  - This sample falls at mid-stop-bit, so the next start edge is at least half a bit away. Back-to-back frames are therefore received without loss.
- Frame completion:
  - If the holding register is empty or is being drained in the same cycle (`!rx_vld || rx_rdy`): load `rx_data`, `parity_err` and `frame_err`; set `rx_vld`=1.
  - Otherwise: drop the frame, leave the held byte untouched, and pulse `overrun` for one cycle.
- A byte with `frame_err` or `parity_err` set is still delivered; the consumer decides what to do with it.
- `rx_vld` falls on the cycle after a transfer, unless a completion lands in that same cycle. In that case it stays high with the new byte.
- Reset mid-frame: state goes to IDLE, counters clear, all outputs go to reset values, and the partial frame is discarded.

## Timing
- Synchronizer latency is 2 cycles. START is entered 3 cycles after the falling edge on the pin.
- Start-bit validation happens BR/2 cycles after START entry.
- Each data/parity/stop sample follows the previous sample by exactly BR cycles.
- `rx_vld` rises on the clock edge after the stop-bit sample, about 10.5×BR+4 cycles after the start edge on the pin when parity is compiled in.
- No combinational path from `rx_rdy` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start + DATA_WIDTH bits + even parity + stop; PARITY state exists.
- Not defined: frame is start + data + stop. PARITY state is removed and `parity_err` is tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams (shared with the TX/command FSM);
  - the default BR constant;
  - the even-parity function.
- Sub-module `uart_rx_sync` contains the 2-flop synchronizer plus the falling-edge detector. It outputs `rx_s` and `fall`.

## Test plan
- 0xA5 sent with parity 0, stop 1, `rx_rdy`=1 → one `rx_vld` pulse; `rx_data`=0xA5; both error flags 0.
- 0x01 sent with parity bit 0 (wrong) → `rx_data`=0x01, `parity_err`=1, `frame_err`=0.
- 0x3C sent with stop bit 0, then line held low for 20 bit times → one byte with `frame_err`=1 and no further `rx_vld`. After the line returns high, a 0x55 frame is received cleanly.
- Low pulse of BR/4 cycles on an idle line → no `rx_vld`, FSM back in IDLE, a following 0x0F frame is received correctly.
- Frames 0x11 and 0x22 sent back-to-back with `rx_rdy`=0 → 0x11 held with `rx_vld`=1. `overrun` pulses once at the end of 0x22. Raising `rx_rdy` then delivers only 0x11.
- `rst` asserted for one cycle during bit 4 of a frame → outputs go to 0 and no `rx_vld` follows. The next full frame, 0xC3, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit period, parity helper.
// Used by the RX front end and the TX/command FSM.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_e;

  // 50 MHz / 115200 baud
  localparam int UART_BR = 434;

  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the rx pin plus a delay flop for
// falling-edge detection; all flops reset to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, stop/parity checks, valid/ready output.
// Even parity bit is present only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BR         = UART_BR,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_vld,
  input  logic                  rx_rdy,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BW = $clog2(BR);
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [BW-1:0] HALF = BW'(BR / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(BR - 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  rx_state_e state;
  rx_state_e state_n;

  logic [BW-1:0]         br_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;

  logic rx_s;
  logic fall;
  logic br_clr;
  logic shift_en;
  logic par_ld;
  logic done;
  logic load;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    br_clr   = 1'b0;
    shift_en = 1'b0;
    par_ld   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          br_clr  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        // a line that is high again at mid-start was a glitch
        if (br_cnt == HALF) begin
          br_clr  = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (br_cnt == FULL) begin
          shift_en = 1'b1;
          br_clr   = 1'b1;
          if (bit_cnt == LAST) state_n = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (br_cnt == FULL) begin
          par_ld  = 1'b1;
          br_clr  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (br_cnt == FULL) begin
          done    = 1'b1;
          br_clr  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load = done && (!rx_vld || rx_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (br_clr || state == IDLE) br_cnt <= '0;
      else                         br_cnt <= br_cnt + 1'b1;
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
      // LSB arrives first, so shifting in at the top lands it at bit 0
      if (shift_en) shift <= {rx_s, shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        rx_data   <= shift;
        frame_err <= ~rx_s;
        rx_vld    <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_ld) perr       <= rx_s ^ even_par(64'(shift));
      if (load)   parity_err <= perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
